// File: rtl/sn76489_wr_queue.sv
// Write queue between a CPU sound port and an SN76489-style PSG.
// Buffers CPU bytes and replays them through a ready/strobe handshake.
module sn76489_wr_queue #(
    parameter int depth_g   = 4,
    parameter int timeout_g = 255
) (
    input  logic                       clock_i,
    input  logic                       res_n_i,
    input  logic                       cpu_wr_i,
    input  logic [0:7]                 cpu_d_i,
    input  logic                       err_clr_i,
    input  logic                       psg_ready_i,
    output logic                       psg_ce_n_o,
    output logic                       psg_we_n_o,
    output logic [0:7]                 psg_d_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(depth_g):0]   level_o,
    output logic                       overflow_o,
    output logic                       timeout_o
);

    localparam int AW = $clog2(depth_g);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH    = CW'(depth_g);
    localparam logic [15:0]   TMO_LAST = 16'(timeout_g - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [0:7]    r_mem [depth_g];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;
    logic [15:0]   r_tmo;
    logic          r_sel_n;
    logic [0:7]    r_psg_d;
    logic          r_empty;
    logic          r_full;
    logic          r_ovf;
    logic          r_tmo_err;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_tmo_hit;
    logic          w_start;
    logic          w_active;

    always_comb begin
        w_pop  = (r_state == ST_RELEASE);
        w_push = cpu_wr_i && ((r_count != DEPTH) || w_pop);
        w_drop = cpu_wr_i && !w_push;
        w_count_nxt = r_count;
        if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
        if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
    end

    // ISSUE gives the timeout priority; WAIT gives a late ack priority.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_hit   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_count != '0) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_RELEASE;
                    w_tmo_hit   = 1'b1;
                end else if (!psg_ready_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (psg_ready_i) begin
                    w_state_nxt = ST_RELEASE;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_RELEASE;
                    w_tmo_hit   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_start  = (r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE);
        w_active = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
    end

    always_ff @(posedge clock_i) begin
        if (res_n_i && w_push) r_mem[r_wr_ptr] <= cpu_d_i;
    end

    always_ff @(posedge clock_i) begin
        if (!res_n_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_state   <= ST_IDLE;
            r_tmo     <= '0;
            r_sel_n   <= 1'b1;
            r_psg_d   <= 8'h00;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel_n <= !w_active;
            if (w_start) begin
                r_psg_d <= r_mem[r_rd_ptr];
                r_tmo   <= '0;
            end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
                r_tmo <= r_tmo + 16'd1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == DEPTH);
            if (w_drop)         r_ovf <= 1'b1;
            else if (err_clr_i) r_ovf <= 1'b0;
            if (w_tmo_hit)      r_tmo_err <= 1'b1;
            else if (err_clr_i) r_tmo_err <= 1'b0;
        end
    end

    // One register feeds both strobes so they can never skew.
    assign psg_ce_n_o = r_sel_n;
    assign psg_we_n_o = r_sel_n;
    assign psg_d_o    = r_psg_d;
    assign empty_o    = r_empty;
    assign full_o     = r_full;
    assign level_o    = r_count;
    assign overflow_o = r_ovf;
    assign timeout_o  = r_tmo_err;

endmodule

// File: tb/tb_sn76489_wr_queue.sv
// Bench for sn76489_wr_queue: vector table, directed corner cases and
// randomized traffic checked against a queue-based reference model.
module tb_sn76489_wr_queue;

    logic       clk = 1'b0;
    logic       res_n;
    logic       cpu_wr;
    logic [0:7] cpu_d;
    logic       err_clr;
    logic       ready;

    logic       ce_a, we_a, emp_a, ful_a, ovf_a, tmo_a;
    logic [0:7] d_a;
    logic [2:0] lvl_a;
    logic       ce_t, we_t, emp_t, ful_t, ovf_t, tmo_t;
    logic [0:7] d_t;
    logic [2:0] lvl_t;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sn76489_wr_queue #(.depth_g(4), .timeout_g(255)) u_dut (
        .clock_i(clk), .res_n_i(res_n), .cpu_wr_i(cpu_wr), .cpu_d_i(cpu_d),
        .err_clr_i(err_clr), .psg_ready_i(ready),
        .psg_ce_n_o(ce_a), .psg_we_n_o(we_a), .psg_d_o(d_a),
        .empty_o(emp_a), .full_o(ful_a), .level_o(lvl_a),
        .overflow_o(ovf_a), .timeout_o(tmo_a)
    );

    sn76489_wr_queue #(.depth_g(4), .timeout_g(16)) u_tmo (
        .clock_i(clk), .res_n_i(res_n), .cpu_wr_i(cpu_wr), .cpu_d_i(cpu_d),
        .err_clr_i(err_clr), .psg_ready_i(ready),
        .psg_ce_n_o(ce_t), .psg_we_n_o(we_t), .psg_d_o(d_t),
        .empty_o(emp_t), .full_o(ful_t), .level_o(lvl_t),
        .overflow_o(ovf_t), .timeout_o(tmo_t)
    );

    typedef struct {
        logic       rst_n;
        logic       wr;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic       ce_n;
        logic [2:0] lvl;
        logic       emp;
        logic       ful;
        logic [7:0] pd;
        logic       ov;
        logic       to;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res_n = 1'b0; cpu_wr = 1'b0; cpu_d = 8'h00; err_clr = 1'b0; ready = 1'b1;
        step();
        res_n = 1'b1;
    endtask

    task automatic psg_write(input int lat, output logic [7:0] b);
        int k;
        k = 0;
        while (ce_a !== 1'b0 && k < 600) begin step(); k++; end
        chk("wait_issue", {31'd0, ce_a}, 32'd0);
        b = d_a;
        ready = 1'b0;
        repeat (lat) step();
        ready = 1'b1;
        k = 0;
        while (ce_a !== 1'b1 && k < 600) begin step(); k++; end
        chk("wait_release", {31'd0, ce_a}, 32'd1);
    endtask

    logic [7:0] q[$];
    logic [7:0] b;
    int  occ, lowcnt, L, bad, rises, n, burst;
    bit  prev_ce, rel_now, acc, exp_ov, exp_to, wr_now;

    initial begin
        res_n = 1'b0; cpu_wr = 1'b0; cpu_d = 8'h00; err_clr = 1'b0; ready = 1'b1;

        tv[0]  = '{0, 0, 8'h00, 1, 0,  1, 0, 1, 0, 8'h00, 0, 0};
        tv[1]  = '{1, 1, 8'h80, 0, 0,  1, 1, 0, 0, 8'h00, 0, 0};
        tv[2]  = '{1, 1, 8'h01, 0, 0,  0, 2, 0, 0, 8'h80, 0, 0};
        tv[3]  = '{1, 1, 8'hA0, 0, 0,  0, 3, 0, 0, 8'h80, 0, 0};
        tv[4]  = '{1, 1, 8'h02, 0, 0,  0, 4, 0, 1, 8'h80, 0, 0};
        tv[5]  = '{1, 1, 8'hBF, 0, 0,  0, 4, 0, 1, 8'h80, 1, 0};
        tv[6]  = '{1, 1, 8'hBF, 0, 1,  0, 4, 0, 1, 8'h80, 1, 0};
        tv[7]  = '{1, 0, 8'h00, 0, 1,  0, 4, 0, 1, 8'h80, 0, 0};
        tv[8]  = '{1, 1, 8'h55, 0, 0,  0, 4, 0, 1, 8'h80, 1, 0};
        tv[9]  = '{1, 0, 8'h00, 1, 0,  1, 4, 0, 1, 8'h80, 1, 0};
        tv[10] = '{1, 0, 8'h00, 1, 0,  1, 3, 0, 0, 8'h80, 1, 0};
        tv[11] = '{1, 0, 8'h00, 1, 0,  0, 3, 0, 0, 8'h01, 1, 0};
        tv[12] = '{1, 0, 8'h00, 0, 0,  0, 3, 0, 0, 8'h01, 1, 0};
        tv[13] = '{0, 1, 8'h77, 0, 0,  1, 0, 1, 0, 8'h00, 0, 0};
        tv[14] = '{1, 0, 8'h00, 1, 0,  1, 0, 1, 0, 8'h00, 0, 0};

        for (int i = 0; i < 15; i++) begin
            res_n = tv[i].rst_n; cpu_wr = tv[i].wr; cpu_d = tv[i].d;
            ready = tv[i].rdy;   err_clr = tv[i].clr;
            step();
            chk($sformatf("tv%0d_ce", i),  {31'd0, ce_a},  {31'd0, tv[i].ce_n});
            chk($sformatf("tv%0d_we", i),  {31'd0, we_a},  {31'd0, tv[i].ce_n});
            chk($sformatf("tv%0d_lvl", i), {29'd0, lvl_a}, {29'd0, tv[i].lvl});
            chk($sformatf("tv%0d_emp", i), {31'd0, emp_a}, {31'd0, tv[i].emp});
            chk($sformatf("tv%0d_ful", i), {31'd0, ful_a}, {31'd0, tv[i].ful});
            chk($sformatf("tv%0d_pd", i),  {24'd0, d_a},   {24'd0, tv[i].pd});
            chk($sformatf("tv%0d_ov", i),  {31'd0, ovf_a}, {31'd0, tv[i].ov});
            chk($sformatf("tv%0d_to", i),  {31'd0, tmo_a}, {31'd0, tv[i].to});
        end

        // single write latency and hold
        do_reset();
        cpu_wr = 1'b1; cpu_d = 8'h9F;
        step();
        cpu_wr = 1'b0;
        chk("s34_n1_lvl", {29'd0, lvl_a}, 32'd1);
        chk("s34_n1_ce", {31'd0, ce_a}, 32'd1);
        step();
        chk("s34_n2_ce", {31'd0, ce_a}, 32'd0);
        chk("s34_n2_d", {24'd0, d_a}, 32'h9F);
        ready = 1'b0; bad = 0; rises = 0;
        repeat (32) begin
            step();
            if (ce_a !== 1'b0 || we_a !== 1'b0 || d_a !== 8'h9F) bad++;
        end
        chk("s34_hold", bad, 0);
        ready = 1'b1;
        step();
        chk("s34_rel_ce", {31'd0, ce_a}, 32'd1);
        chk("s34_rel_d", {24'd0, d_a}, 32'h9F);
        rises = 1;
        step();
        chk("s34_empty", {31'd0, emp_a}, 32'd1);
        chk("s34_lvl0", {29'd0, lvl_a}, 32'd0);
        repeat (4) begin
            step();
            if (ce_a !== 1'b1) rises++;
        end
        chk("s34_one_release", rises, 1);
        chk("s34_no_tmo", {31'd0, tmo_a}, 32'd0);

        // full FIFO with a push landing on the release cycle
        do_reset();
        cpu_wr = 1'b1;
        cpu_d = 8'h11; step();
        cpu_d = 8'h22; step();
        cpu_d = 8'h33; step();
        cpu_d = 8'h44; step();
        cpu_wr = 1'b0;
        chk("s36_full", {31'd0, ful_a}, 32'd1);
        chk("s36_lvl4", {29'd0, lvl_a}, 32'd4);
        ready = 1'b0; step();
        ready = 1'b1; step();
        chk("s36_rel_ce", {31'd0, ce_a}, 32'd1);
        cpu_wr = 1'b1; cpu_d = 8'h55;
        step();
        cpu_wr = 1'b0;
        chk("s36_lvl_keep", {29'd0, lvl_a}, 32'd4);
        chk("s36_full_keep", {31'd0, ful_a}, 32'd1);
        chk("s36_no_ovf", {31'd0, ovf_a}, 32'd0);
        psg_write(2, b); chk("s36_order0", {24'd0, b}, 32'h22);
        psg_write(1, b); chk("s36_order1", {24'd0, b}, 32'h33);
        psg_write(3, b); chk("s36_order2", {24'd0, b}, 32'h44);
        psg_write(1, b); chk("s36_order3", {24'd0, b}, 32'h55);
        step(); step();
        chk("s36_drained", {31'd0, emp_a}, 32'd1);

        // timeout on the short-timeout instance
        do_reset();
        cpu_wr = 1'b1;
        cpu_d = 8'hA1; step();
        cpu_d = 8'hA2; step();
        cpu_wr = 1'b0;
        chk("s37_issue_ce", {31'd0, ce_t}, 32'd0);
        chk("s37_issue_d", {24'd0, d_t}, 32'hA1);
        n = 0;
        while (ce_t === 1'b0 && n < 100) begin step(); n++; end
        chk("s37_cycles", n, 16);
        chk("s37_tmo_set", {31'd0, tmo_t}, 32'd1);
        step(); step();
        chk("s37_next_ce", {31'd0, ce_t}, 32'd0);
        chk("s37_next_d", {24'd0, d_t}, 32'hA2);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("s37_tmo_clr", {31'd0, tmo_t}, 32'd0);

        // randomized bursts against the reference queue
        do_reset();
        q.delete();
        occ = 0; lowcnt = 0; prev_ce = 1'b1; exp_ov = 1'b0; exp_to = 1'b0;
        burst = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            rel_now = (ce_a === 1'b1) && !prev_ce;
            if (ce_a === 1'b0 && prev_ce) begin
                chk("rnd_issue_nonempty", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) chk("rnd_order", {24'd0, d_a}, {24'd0, q.pop_front()});
                L = $urandom_range(0, 40);
                lowcnt = L;
                if (L == 0) exp_to = 1'b1;
            end
            prev_ce = (ce_a === 1'b1);
            ready = (lowcnt > 0) ? 1'b0 : 1'b1;
            if (lowcnt > 0) lowcnt--;
            if (burst == 0) burst = $urandom_range(0, 20);
            else burst--;
            wr_now = (cyc < 4000) && (burst > 8) && ($urandom_range(0, 9) < 7);
            cpu_wr = wr_now;
            cpu_d = 8'($urandom);
            acc = wr_now && (occ < 4 || rel_now);
            if (wr_now && !acc) exp_ov = 1'b1;
            if (acc) q.push_back(cpu_d);
            step();
            occ = occ + int'(acc) - int'(rel_now);
            chk("rnd_level", {29'd0, lvl_a}, occ);
        end
        cpu_wr = 1'b0;
        chk("rnd_all_issued", q.size(), 0);
        chk("rnd_occ0", occ, 0);
        chk("rnd_ovf", {31'd0, ovf_a}, {31'd0, exp_ov});
        chk("rnd_tmo", {31'd0, tmo_a}, {31'd0, exp_to});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sn76489_wr_queue.md
SN76489_WR_QUEUE -- requirements
Module: sn76489_wr_queue

Interface
REQ-001 Parameter: depth_g, 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter: timeout_g, 255, max cycles a single PSG write may stay un-completed; range 8..65535.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clock_i  in  1  system clock, rising-edge.
REQ-005 res_n_i  in  1  synchronous active-low reset.
REQ-006 cpu_wr_i  in  1  one-cycle strobe; CPU write to the sound port.
REQ-007 cpu_d_i  in  8 [0:7]  CPU write data, bit 0 = MSB.
REQ-008 err_clr_i  in  1  clears sticky error flags.
REQ-009 psg_ready_i  in  1  ready from sound chip; low = write in progress.
REQ-010 psg_ce_n_o  out  1  chip enable to sound chip, active-low.
REQ-011 psg_we_n_o  out  1  write enable to sound chip, active-low.
REQ-012 psg_d_o  out  8 [0:7]  data to sound chip.
REQ-013 empty_o / full_o  out  1 each  FIFO status.
REQ-014 level_o  out  clog2(depth_g)+1  current entry count.
REQ-015 overflow_o  out  1  sticky: write dropped because FIFO full.
REQ-016 timeout_o  out  1  sticky: a PSG write hit timeout_g.

Function
REQ-017 FIFO: circular buffer, wrapping read/write pointers, count register; all outputs registered.
REQ-018 Push: cpu_wr_i=1 and (count<depth_g or pop this cycle) stores cpu_d_i; else data dropped, overflow_o set next cycle.
REQ-019 Simultaneous push and pop when full: push accepted, count unchanged.
REQ-020 FSM states: IDLE, ISSUE, WAIT, RELEASE.
REQ-021 IDLE: ce_n/we_n high; if count>0 (registered, i.e. after a push is visible) -> ISSUE, latching head entry into psg_d_o.
REQ-022 ISSUE: ce_n=0, we_n=0; psg_ready_i=0 -> WAIT; else stay.
REQ-023 WAIT: ce_n=0, we_n=0; psg_ready_i=1 -> RELEASE.
REQ-024 RELEASE: ce_n/we_n high for exactly one cycle; head entry popped this cycle; -> IDLE.
REQ-025 psg_d_o stable from ISSUE entry through RELEASE; changes only on IDLE->ISSUE.
REQ-026 Latency: push into empty FIFO at cycle N -> count=1 at N+1 -> psg_ce_n_o low at N+2.
REQ-027 Back-to-back entries: minimum one IDLE cycle between RELEASE and next ISSUE.
REQ-028 Timeout counter: cleared on entering ISSUE, increments each cycle in ISSUE/WAIT; on reaching timeout_g-1 -> RELEASE (entry popped), timeout_o set.
REQ-029 err_clr_i clears overflow_o and timeout_o next cycle; a same-cycle new error wins (flag stays set).
REQ-030 Glitch rule: psg_ce_n_o and psg_we_n_o always change together, driven from the same register.

Reset
REQ-031 res_n_i=0 at a clock edge: FIFO empty, pointers 0, level_o=0, empty_o=1, full_o=0, FSM IDLE, psg_ce_n_o=1, psg_we_n_o=1, psg_d_o=0x00, overflow_o=0, timeout_o=0, timeout counter 0.
REQ-032 Reset mid-write (ISSUE/WAIT) aborts immediately: ce_n/we_n high next edge, all queued data discarded, no error flags set.
REQ-033 cpu_wr_i ignored while res_n_i=0.

Verification
REQ-034 Single write 0x9F, PSG model drops ready 1 cycle after ce_n low for 32 cycles -> ce_n low at N+2, psg_d_o=0x9F throughout, one RELEASE, empty_o=1 afterwards.
REQ-035 depth_g=4: 5 consecutive strobes 0x80,0x01,0xA0,0x02,0xBF with ready stuck low -> first four queued, 0xBF dropped, overflow_o=1, full_o=1 until first pop.
REQ-036 FIFO full and cpu_wr_i coincident with RELEASE pop -> write accepted, level_o stays 4, output order preserved after pointer wrap.
REQ-037 timeout_g=16, psg_ready_i held high (never acknowledges) -> RELEASE 16 cycles after ISSUE entry, timeout_o=1, next entry issued; err_clr_i pulse -> timeout_o=0.
REQ-038 Reset asserted in WAIT with 3 entries queued -> next edge: ce_n/we_n=1, level_o=0, psg_d_o=0x00, flags 0.
REQ-039 Random write bursts vs. randomized ready latency (0..40 cycles): byte sequence on completed PSG writes equals accepted CPU sequence.
